// File: rtl/stack_mem_responder_if.sv
// Bus bundle between the stack-machine responder, the host loader and the core.
interface stack_mem_responder_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_last;
    logic             load_ready;
    logic             restart;
    logic [7:0]       mem_addr;
    logic [WIDTH-1:0] rd_data;
    logic             core_reset;
    logic [WIDTH-1:0] core_out;
    logic             out_change;
    logic [WIDTH-1:0] result;
    logic             running;
    logic [15:0]      run_cycles;

    // Responder side
    modport slave (
        input  load_valid, load_data, load_last, restart, mem_addr, core_out,
        output load_ready, rd_data, core_reset, out_change, result, running, run_cycles
    );

    // Host / core side
    modport master (
        output load_valid, load_data, load_last, restart, mem_addr, core_out,
        input  load_ready, rd_data, core_reset, out_change, result, running, run_cycles
    );
endinterface

// File: rtl/stack_mem_responder.sv
// Program-memory responder for the stack machine core: loads bytes from the
// host while the core is held in reset, then serves core reads and watches
// the core's output for changes.
module stack_mem_responder #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    stack_mem_responder_if.slave  bus
);
    localparam int             AW      = $clog2(DEPTH);
    localparam logic [8:0]     DEPTH_9 = 9'(DEPTH);
    localparam logic [AW-1:0]  LAST_AD = AW'(DEPTH - 1);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [AW-1:0]    r_wr_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;
    logic [WIDTH-1:0] r_result;
    logic             r_out_change;
    logic [15:0]      r_run_cycles;

    logic             w_load_ready;
    logic             w_core_reset;
    logic             w_running;
    logic             w_wr_en;
    logic             w_ptr_at_end;
    logic             w_addr_in_range;
    logic [DEPTH-1:0] w_wr_sel;

    // Writing the top address forces RUN, so the pointer never needs to wrap.
    assign w_ptr_at_end    = (r_wr_ptr == LAST_AD);
    // Full 8-bit compare so high addresses never alias into memory.
    assign w_addr_in_range = ({1'b0, bus.mem_addr} < DEPTH_9);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and state-decoded outputs; restart overrides everything
    always_comb begin
        w_state_next = r_state;
        w_load_ready = 1'b0;
        w_core_reset = 1'b1;
        w_running    = 1'b0;
        w_wr_en      = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_load_ready = !reset;
                // A restart in the same cycle drops the offered byte.
                w_wr_en      = bus.load_valid && w_load_ready && !bus.restart;
                if (w_wr_en && (bus.load_last || w_ptr_at_end)) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_core_reset = 1'b0;
                w_running    = 1'b1;
            end
            default: w_state_next = S_LOAD;
        endcase
        if (bus.restart) begin
            w_state_next = S_LOAD;
        end
    end

    // Per-location write strobes decoded from the load pointer
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign w_wr_sel[gi] = w_wr_en && (r_wr_ptr == AW'(gi));
        end
    endgenerate

    // Flop memory: cleared by reset only, so a partial reload keeps old bytes
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                r_mem[i] <= '0;
            end else if (w_wr_sel[i]) begin
                r_mem[i] <= bus.load_data;
            end
        end
    end

    // Load pointer: restarts at zero on reset or restart
    always_ff @(posedge clock) begin
        if (reset || bus.restart) begin
            r_wr_ptr <= '0;
        end else if (w_wr_en && !w_ptr_at_end) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
        end
    end

    // RUN datapath: registered read, output monitor and saturating cycle count
    always_ff @(posedge clock) begin
        if (reset || bus.restart) begin
            r_rd_data    <= '0;
            r_result     <= '0;
            r_out_change <= 1'b0;
            r_run_cycles <= '0;
        end else if (r_state == S_RUN) begin
            r_rd_data    <= w_addr_in_range ? r_mem[bus.mem_addr[AW-1:0]] : '0;
            r_result     <= bus.core_out;
            r_out_change <= (bus.core_out != r_result);
            if (r_run_cycles != 16'hFFFF) begin
                r_run_cycles <= r_run_cycles + 16'd1;
            end
        end else begin
            r_rd_data    <= '0;
            r_out_change <= 1'b0;
        end
    end

    assign bus.load_ready = w_load_ready;
    assign bus.core_reset = w_core_reset;
    assign bus.running    = w_running;
    assign bus.rd_data    = r_rd_data;
    assign bus.result     = r_result;
    assign bus.out_change = r_out_change;
    assign bus.run_cycles = r_run_cycles;
endmodule

// File: tb/tb_stack_mem_responder.sv
// Directed bench for stack_mem_responder: table of single-cycle vectors plus
// hand-written sequences for full load, saturation and reset corner cases.
module tb_stack_mem_responder;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    stack_mem_responder_if #(.WIDTH(8)) bus_if ();

    stack_mem_responder #(.DEPTH(32), .WIDTH(8)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        lv;
        logic [7:0]  ld;
        logic        ll;
        logic        rs;
        logic [7:0]  addr;
        logic [7:0]  co;
        logic        e_ready;
        logic        e_creset;
        logic        e_run;
        logic [7:0]  e_rd;
        logic        e_oc;
        logic [7:0]  e_res;
        logic [15:0] e_cyc;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(input logic lv, input logic [7:0] ld, input logic ll,
                                input logic rs, input logic [7:0] addr, input logic [7:0] co,
                                input logic e_ready, input logic e_creset, input logic e_run,
                                input logic [7:0] e_rd, input logic e_oc, input logic [7:0] e_res,
                                input logic [15:0] e_cyc);
        vec_t v;
        v.lv = lv; v.ld = ld; v.ll = ll; v.rs = rs; v.addr = addr; v.co = co;
        v.e_ready = e_ready; v.e_creset = e_creset; v.e_run = e_run;
        v.e_rd = e_rd; v.e_oc = e_oc; v.e_res = e_res; v.e_cyc = e_cyc;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " load_ready"}, 32'(bus_if.load_ready), 32'(0));
        check({tag, " core_reset"}, 32'(bus_if.core_reset), 32'(1));
        check({tag, " running"},    32'(bus_if.running),    32'(0));
        check({tag, " rd_data"},    32'(bus_if.rd_data),    32'(0));
        check({tag, " out_change"}, 32'(bus_if.out_change), 32'(0));
        check({tag, " result"},     32'(bus_if.result),     32'(0));
        check({tag, " run_cycles"}, 32'(bus_if.run_cycles), 32'(0));
    endtask

    task automatic drive(input logic lv, input logic [7:0] ld, input logic ll, input logic rs);
        bus_if.load_valid = lv;
        bus_if.load_data  = ld;
        bus_if.load_last  = ll;
        bus_if.restart    = rs;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //            lv  ld     ll rs addr   co     rdy cr run rd     oc res    cyc
        vecs[0]  = mk(H, 8'h11, L, L, 8'h00, 8'h00, H, H, L, 8'h00, L, 8'h00, 16'd0);
        vecs[1]  = mk(H, 8'h22, L, L, 8'h00, 8'h00, H, H, L, 8'h00, L, 8'h00, 16'd0);
        vecs[2]  = mk(H, 8'h33, L, L, 8'h00, 8'h00, H, H, L, 8'h00, L, 8'h00, 16'd0);
        vecs[3]  = mk(H, 8'h44, H, L, 8'h00, 8'h00, L, L, H, 8'h00, L, 8'h00, 16'd0);
        vecs[4]  = mk(L, 8'h00, L, L, 8'h02, 8'h00, L, L, H, 8'h33, L, 8'h00, 16'd1);
        vecs[5]  = mk(L, 8'h00, L, L, 8'h00, 8'h05, L, L, H, 8'h11, H, 8'h05, 16'd2);
        vecs[6]  = mk(L, 8'h00, L, L, 8'h01, 8'h05, L, L, H, 8'h22, L, 8'h05, 16'd3);
        vecs[7]  = mk(L, 8'h00, L, L, 8'h03, 8'h09, L, L, H, 8'h44, H, 8'h09, 16'd4);
        vecs[8]  = mk(L, 8'h00, L, L, 8'h04, 8'h09, L, L, H, 8'h00, L, 8'h09, 16'd5);
        vecs[9]  = mk(H, 8'h77, H, H, 8'h01, 8'h09, H, H, L, 8'h00, L, 8'h00, 16'd0);
        vecs[10] = mk(H, 8'hAA, H, L, 8'h00, 8'h00, L, L, H, 8'h00, L, 8'h00, 16'd0);
        vecs[11] = mk(L, 8'h00, L, L, 8'h00, 8'h00, L, L, H, 8'hAA, L, 8'h00, 16'd1);
        vecs[12] = mk(L, 8'h00, L, L, 8'h01, 8'h00, L, L, H, 8'h22, L, 8'h00, 16'd2);
        vecs[13] = mk(L, 8'h00, L, H, 8'h00, 8'h00, H, H, L, 8'h00, L, 8'h00, 16'd0);
        vecs[14] = mk(H, 8'h55, H, H, 8'h00, 8'h00, H, H, L, 8'h00, L, 8'h00, 16'd0);
        vecs[15] = mk(H, 8'h66, H, L, 8'h00, 8'h00, L, L, H, 8'h00, L, 8'h00, 16'd0);
        vecs[16] = mk(L, 8'h00, L, L, 8'h00, 8'h00, L, L, H, 8'h66, L, 8'h00, 16'd1);
        vecs[17] = mk(L, 8'h00, L, L, 8'h01, 8'h00, L, L, H, 8'h22, L, 8'h00, 16'd2);

        drive(L, 8'h00, L, L);
        bus_if.mem_addr = 8'h00;
        bus_if.core_out = 8'h00;
        rst = 1'b1;
        tick();
        tick();
        check_reset_vals("reset");
        $display("reset: load_ready=%0b core_reset=%0b", bus_if.load_ready, bus_if.core_reset);
        rst = 1'b0;
        #1;
        check("ready after reset", 32'(bus_if.load_ready), 32'(1));

        // Table-driven single-cycle vectors
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].lv, vecs[i].ld, vecs[i].ll, vecs[i].rs);
            bus_if.mem_addr = vecs[i].addr;
            bus_if.core_out = vecs[i].co;
            tick();
            check($sformatf("v%0d load_ready", i), 32'(bus_if.load_ready), 32'(vecs[i].e_ready));
            check($sformatf("v%0d core_reset", i), 32'(bus_if.core_reset), 32'(vecs[i].e_creset));
            check($sformatf("v%0d running", i),    32'(bus_if.running),    32'(vecs[i].e_run));
            check($sformatf("v%0d rd_data", i),    32'(bus_if.rd_data),    32'(vecs[i].e_rd));
            check($sformatf("v%0d out_change", i), 32'(bus_if.out_change), 32'(vecs[i].e_oc));
            check($sformatf("v%0d result", i),     32'(bus_if.result),     32'(vecs[i].e_res));
            check($sformatf("v%0d run_cycles", i), 32'(bus_if.run_cycles), 32'(vecs[i].e_cyc));
            $display("vec %0d: lv=%0b rs=%0b addr=%02h co=%02h -> run=%0b rd=%02h oc=%0b res=%02h cyc=%0d",
                     i, vecs[i].lv, vecs[i].rs, vecs[i].addr, vecs[i].co, bus_if.running,
                     bus_if.rd_data, bus_if.out_change, bus_if.result, bus_if.run_cycles);
        end

        // Full 32-byte load without load_last
        drive(L, 8'h00, L, H);
        tick();
        for (int i = 0; i < 32; i++) begin
            drive(H, 8'(8'hA0 + i), L, L);
            tick();
            check($sformatf("full byte %0d running", i), 32'(bus_if.running), 32'(i == 31));
        end
        $display("full load: running=%0b load_ready=%0b", bus_if.running, bus_if.load_ready);
        check("full load_ready drop", 32'(bus_if.load_ready), 32'(0));
        drive(H, 8'hFF, L, L);
        bus_if.mem_addr = 8'd31;
        tick();
        drive(L, 8'h00, L, L);
        check("full rd addr31", 32'(bus_if.rd_data), 32'hBF);
        bus_if.mem_addr = 8'h40;
        tick();
        check("full rd addr40", 32'(bus_if.rd_data), 32'h00);
        bus_if.mem_addr = 8'h21;
        tick();
        check("full rd addr21", 32'(bus_if.rd_data), 32'h00);
        bus_if.mem_addr = 8'h00;
        tick();
        check("full rd addr0", 32'(bus_if.rd_data), 32'hA0);
        $display("full load reads done: addr0=%02h", bus_if.rd_data);

        // Saturation of run_cycles
        drive(L, 8'h00, L, H);
        tick();
        drive(H, 8'h01, H, L);
        tick();
        drive(L, 8'h00, L, L);
        check("sat start running", 32'(bus_if.running), 32'(1));
        check("sat start cycles", 32'(bus_if.run_cycles), 32'(0));
        bus_if.core_out = 8'h07;
        repeat (65534) tick();
        check("sat cycles FFFE", 32'(bus_if.run_cycles), 32'hFFFE);
        tick();
        check("sat cycles FFFF", 32'(bus_if.run_cycles), 32'hFFFF);
        repeat (5) tick();
        check("sat cycles hold", 32'(bus_if.run_cycles), 32'hFFFF);
        check("sat result", 32'(bus_if.result), 32'h07);
        $display("saturation: run_cycles=%04h result=%02h", bus_if.run_cycles, bus_if.result);

        // Reset in RUN, then reset mid-load after three bytes
        rst = 1'b1;
        tick();
        check_reset_vals("run reset");
        bus_if.core_out = 8'h00;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(H, 8'(8'hC1 + i), L, L);
            tick();
            check($sformatf("midload byte %0d running", i), 32'(bus_if.running), 32'(0));
        end
        drive(L, 8'h00, L, L);
        rst = 1'b1;
        tick();
        check_reset_vals("load reset");
        rst = 1'b0;
        drive(H, 8'h5A, H, L);
        tick();
        drive(L, 8'h00, L, L);
        check("reload running", 32'(bus_if.running), 32'(1));
        for (int a = 0; a < 32; a++) begin
            bus_if.mem_addr = 8'(a);
            tick();
            check($sformatf("cleared rd addr%0d", a), 32'(bus_if.rd_data),
                  (a == 0) ? 32'h5A : 32'h00);
        end
        bus_if.mem_addr = 8'hFF;
        tick();
        check("cleared rd addrFF", 32'(bus_if.rd_data), 32'h00);
        $display("post-reset sweep done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stack_mem_responder.md
# stack_mem_responder

Memory-side responder for the stack machine core: answers the core's `mem_addr` requests with program bytes from a small internal flop memory. The same memory is loaded from a host byte stream while the core is held in reset. It sits beside the core inside the top-level wrapper: it drives the core's `data_in` and `reset`, and watches the core's `data_out` to flag result changes to the host.

## Interface
Parameters:
- `DEPTH`, 32: program memory size in bytes; power of two, 2..256.
- `WIDTH`, 8: byte width; fixed at 8 for the core.

Ports:
- `clock`  in  1  single system clock; all logic rises on its positive edge.
- `reset`  in  1  synchronous, active-high reset.
- `load_valid`  in  1  host byte present on `load_data`.
- `load_data`  in  8  program byte from the host.
- `load_last`  in  1  qualifies the final byte of the program, valid with `load_valid`.
- `load_ready`  out  1  responder accepts a load byte this cycle.
- `restart`  in  1  single-cycle request to return to loading.
- `mem_addr`  in  8  byte address driven by the core.
- `rd_data`  out  8  byte returned to the core, wired to the core's `data_in`.
- `core_reset`  out  1  holds the core in reset while high.
- `core_out`  in  8  the core's `data_out`.
- `out_change`  out  1  one-cycle pulse when `core_out` changes during RUN.
- `result`  out  8  last sampled `core_out` value.
- `running`  out  1  high in RUN.
- `run_cycles`  out  16  number of RUN cycles; saturates.

## Operation
- FSM has two states: LOAD and RUN. Reset enters LOAD.
- LOAD:
  - `load_ready`=1 and `core_reset`=1.
  - A handshake is `load_valid && load_ready`. It writes `load_data` to `mem[wr_ptr]`, then increments `wr_ptr`.
  - A handshake with `load_last`=1, or a handshake that writes address DEPTH-1, moves to RUN on the next edge.
  - `load_valid` with `load_ready`=0 is ignored; the byte is not written.
- RUN:
  - `load_ready`=0, `core_reset`=0, `running`=1.
  - Read: `rd_data` <= (`mem_addr` < DEPTH) ? `mem[mem_addr]` : 8'h00. Addresses at or above DEPTH never alias into memory.
  - Output monitor: each RUN cycle `result` <= `core_out`. `out_change` <= (`core_out` != `result`).
  - `run_cycles` increments each RUN cycle and saturates at 16'hFFFF.
- `restart`=1 in any state, on the next edge:
  - state goes to LOAD, `wr_ptr`=0, `run_cycles`=0, `result`=0, `out_change`=0, `rd_data`=0.
  - Memory contents are kept. `restart` has priority over a simultaneous load handshake, and that byte is dropped.
- Memory:
  - Reset clears all locations to 0.
  - A partial reload after `restart` overwrites only the bytes it writes; all other locations keep their previous contents.
- Width rules:
  - `wr_ptr` is $clog2(DEPTH) bits wide and never wraps, because writing address DEPTH-1 forces RUN.
  - `mem_addr` compares at the full 8 bits.

## Timing
- Reset values:
  - `load_ready`=0 in the reset cycle, then 1 from the first cycle after reset deasserts.
  - `core_reset`=1, `rd_data`=0, `out_change`=0, `result`=0, `running`=0, `run_cycles`=0, state=LOAD, `wr_ptr`=0.
  - The memory array is cleared.
- Load throughput: 1 byte per cycle while `load_valid` is held high.
- LOAD to RUN:
  - The edge that accepts the last byte sets `running`=1 and `core_reset`=0. Both are visible in the following cycle.
  - The core leaves reset that cycle.
- Read latency: 1 cycle. `mem_addr` sampled at edge N gives `rd_data` valid after edge N. `rd_data` holds 0 throughout LOAD.
- `out_change` is asserted the cycle after `core_out` differs from `result`, for exactly 1 cycle per change.
- The first RUN cycle compares against `result`=0, so a nonzero initial `core_out` pulses `out_change` once.
- Reset has priority over `restart`. Reset mid-RUN clears memory and returns to LOAD with all reset values.

## Test plan
- Load 4 bytes 8'h11,8'h22,8'h33,8'h44 back-to-back, `load_last` on the 4th → `running` rises the cycle after the 4th handshake. `mem_addr`=2 returns `rd_data`=8'h33 one cycle later.
- Load exactly 32 bytes with `load_last` never asserted (DEPTH=32) → transition to RUN after byte 32, and `load_ready` drops. `mem_addr`=31 reads byte 32. `mem_addr`=8'h40 reads 8'h00.
- In RUN, drive `core_out` through 0, 5, 5, 9 → `out_change` pulses exactly twice, and `result` ends at 9.
- Pulse `restart` in RUN together with `load_valid` → state LOAD, `core_reset`=1, that byte is not written, and `run_cycles`=0. Reload 1 byte 8'hAA with `load_last` → `mem[0]`=8'hAA while `mem[1]` keeps its old value.
- Hold RUN for 70000 cycles → `run_cycles` saturates at 16'hFFFF.
- Assert `reset` mid-load after 3 bytes → all outputs return to reset values, and every memory address reads 8'h00 after a fresh 1-byte load.
